// File: rtl/toggle_storm_pkg.sv
// Shared types and constants for the toggle_storm power-virus block:
// ramp FSM states, checker LFSR parameters and the lane ramp increment.
package toggle_storm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } ramp_state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
  localparam int          RAMP_INC  = 8;

  // Right-shifting Galois step: feedback taps applied when the bit shifted out is 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/lfsr_pair_check.sv
// Integrity checker: two identically seeded LFSRs that must stay in lockstep;
// any divergence is reported one cycle later on a registered mismatch flag.
module lfsr_pair_check
  import toggle_storm_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic clk,
  input  logic arst,
  input  logic sclr,
  input  logic inject,
  output logic mismatch
);

  localparam logic [31:0] SEED = LFSR_SEED + 32'(IDX);

  logic [31:0] pri_q, pri_d;
  logic [31:0] sh_q, sh_d;
  logic        mm_q, mm_d;

  // A clear reseeds both copies and drops the pending flag; it overrides inject.
  always_comb begin
    pri_d = lfsr_next(pri_q);
    sh_d  = lfsr_next(sh_q) ^ {31'b0, inject};
    mm_d  = (pri_q != sh_q);
    if (sclr) begin
      pri_d = SEED;
      sh_d  = SEED;
      mm_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pri_q <= SEED;
      sh_q  <= SEED;
      mm_q  <= 1'b0;
    end else begin
      pri_q <= pri_d;
      sh_q  <= sh_d;
      mm_q  <= mm_d;
    end
  end

  assign mismatch = mm_q;

endmodule

// File: rtl/toggle_storm.sv
// Switching-activity generator: ramps a bank of toggling lane accumulators up
// and down under duty control, alongside free-running LFSR integrity checkers.
module toggle_storm
  import toggle_storm_pkg::*;
#(
  parameter int NUM_CHAN  = 64,
  parameter int ADD_BITS  = 6,
  parameter int DUTY_BITS = 4,
  parameter int RAMP_STEP = 16,
  parameter int CHECKERS  = 16
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      ena,
  input  logic [DUTY_BITS-1:0]      duty,
  input  logic                      sclr_err,
  input  logic                      inject_err,
  output logic                      dout,
  output logic [$clog2(NUM_CHAN):0] active_chans,
  output logic                      sticky_err,
  output logic [15:0]               err_count,
  output logic [5:0]                first_err_idx,
  output ramp_state_e               dbg_state
);

  localparam int AW = $clog2(NUM_CHAN) + 1;
  localparam int TW = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;

  ramp_state_e   state_q, state_d;
  logic [AW-1:0] act_q, act_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          step_done;

  assign step_done = (tmr_q == TW'(RAMP_STEP - 1));

  // The step timer is zeroed on every state change and on every completed step.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    tmr_d   = '0;
    case (state_q)
      IDLE: if (ena) state_d = RAMP_UP;
      RAMP_UP: begin
        if (!ena) state_d = RAMP_DOWN;
        else if (act_q == AW'(NUM_CHAN)) state_d = RUN;
        else if (step_done) begin
          act_d = act_q + AW'(RAMP_INC);
          if (act_d == AW'(NUM_CHAN)) state_d = RUN;
        end else tmr_d = tmr_q + TW'(1);
      end
      RUN: if (!ena) state_d = RAMP_DOWN;
      RAMP_DOWN: begin
        if (ena) state_d = RAMP_UP;
        else if (act_q == '0) state_d = IDLE;
        else if (step_done) begin
          act_d = act_q - AW'(RAMP_INC);
          if (act_d == '0) state_d = IDLE;
        end else tmr_d = tmr_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  logic [DUTY_BITS-1:0] dcnt_q;
  logic                 burst_on;
  logic [NUM_CHAN-1:0]  en_q, en_d;
  logic [ADD_BITS-1:0]  acc_q [NUM_CHAN];
  logic [ADD_BITS-1:0]  acc_d [NUM_CHAN];
  logic [ADD_BITS-1:0]  acc_x;
  logic                 dout_q;

  assign burst_on = (dcnt_q < duty);

  always_comb begin
    acc_x = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      en_d[i]  = (AW'(i) < act_q) && burst_on;
      acc_d[i] = en_q[i] ? ({acc_q[i][ADD_BITS-2:0], acc_q[i][ADD_BITS-1]} + ADD_BITS'(i + 1))
                         : acc_q[i];
      acc_x    = acc_x ^ acc_q[i];
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      act_q   <= '0;
      tmr_q   <= '0;
      dcnt_q  <= '0;
      en_q    <= '0;
      dout_q  <= 1'b0;
      for (int i = 0; i < NUM_CHAN; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      tmr_q   <= tmr_d;
      dcnt_q  <= dcnt_q + DUTY_BITS'(1);
      en_q    <= en_d;
      dout_q  <= ^acc_x;
      for (int i = 0; i < NUM_CHAN; i++) acc_q[i] <= acc_d[i];
    end
  end

  logic [CHECKERS-1:0] mm_vec;

  for (genvar c = 0; c < CHECKERS; c++) begin : g_chk
    lfsr_pair_check #(.IDX(c)) u_chk (
      .clk      (clk),
      .arst     (arst),
      .sclr     (sclr_err),
      .inject   ((c == 0) ? inject_err : 1'b0),
      .mismatch (mm_vec[c])
    );
  end

  logic        any_mm;
  logic [5:0]  low_idx;
  logic        sticky_q, sticky_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  idx_q, idx_d;

  assign any_mm = |mm_vec;

  // A registered mismatch outranks a simultaneous clear.
  always_comb begin
    low_idx = '0;
    for (int c = CHECKERS - 1; c >= 0; c--) if (mm_vec[c]) low_idx = 6'(c);
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    if (sclr_err) begin
      sticky_d = any_mm;
      cnt_d    = {15'b0, any_mm};
      idx_d    = any_mm ? low_idx : 6'd0;
    end else if (any_mm) begin
      sticky_d = 1'b1;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      if (!sticky_q) idx_d = low_idx;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
    end
  end

  assign dout          = dout_q;
  assign active_chans  = act_q;
  assign sticky_err    = sticky_q;
  assign err_count     = cnt_q;
  assign first_err_idx = idx_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_toggle_storm.sv
// Bench for toggle_storm: ramp vector table, error inject/clear sequences,
// duty and async-reset corners, and randomized cycles against a reference model.
module tb_toggle_storm;
  import toggle_storm_pkg::*;

  localparam int NCH = 64;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        ena = 1'b0;
  logic [3:0]  duty = 4'd4;
  logic        sclr_err = 1'b0;
  logic        inject_err = 1'b0;
  logic        dout;
  logic [6:0]  active_chans;
  logic        sticky_err;
  logic [15:0] err_count;
  logic [5:0]  first_err_idx;
  ramp_state_e dbg_state;

  toggle_storm #(
    .NUM_CHAN(NCH), .ADD_BITS(6), .DUTY_BITS(4), .RAMP_STEP(16), .CHECKERS(16)
  ) dut (
    .clk(clk), .arst(arst), .ena(ena), .duty(duty), .sclr_err(sclr_err),
    .inject_err(inject_err), .dout(dout), .active_chans(active_chans),
    .sticky_err(sticky_err), .err_count(err_count), .first_err_idx(first_err_idx),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: behaviour derived from the ramp/duty/lane/checker rules.
  ramp_state_e m_mode;
  int          m_act, m_tmr, m_dcnt;
  bit          m_en [NCH];
  bit [5:0]    m_acc [NCH];
  bit          m_dout;
  bit [31:0]   m_diff;
  bit          m_mm, m_sticky;
  int          m_cnt;
  int          m_idx;

  function automatic bit [31:0] gstep(input bit [31:0] s);
    bit lsb;
    lsb = s[0];
    s = s >> 1;
    if (lsb) s = s ^ 32'h8020_0003;
    return s;
  endfunction

  task automatic m_reset();
    m_mode = IDLE; m_act = 0; m_tmr = 0; m_dcnt = 0; m_dout = 0;
    m_diff = 0; m_mm = 0; m_sticky = 0; m_cnt = 0; m_idx = 0;
    for (int i = 0; i < NCH; i++) begin m_en[i] = 0; m_acc[i] = 0; end
  endtask

  task automatic model_step();
    bit [5:0] x;
    bit       any;
    if (arst) begin m_reset(); return; end
    x = 0;
    for (int i = 0; i < NCH; i++) x = x ^ m_acc[i];
    m_dout = ^x;
    for (int i = 0; i < NCH; i++) begin
      if (m_en[i]) m_acc[i] = {m_acc[i][4:0], m_acc[i][5]} + 6'(i + 1);
      m_en[i] = (i < m_act) && (m_dcnt < int'(duty));
    end
    m_dcnt = (m_dcnt + 1) % 16;
    if (m_mode == IDLE) begin
      if (ena) begin m_mode = RAMP_UP; m_tmr = 0; end
    end else if (m_mode == RUN) begin
      if (!ena) begin m_mode = RAMP_DOWN; m_tmr = 0; end
    end else if (m_mode == RAMP_UP) begin
      if (!ena) begin m_mode = RAMP_DOWN; m_tmr = 0; end
      else if (m_act == NCH) begin m_mode = RUN; m_tmr = 0; end
      else if (m_tmr == 15) begin
        m_act += 8; m_tmr = 0;
        if (m_act == NCH) m_mode = RUN;
      end else m_tmr++;
    end else begin
      if (ena) begin m_mode = RAMP_UP; m_tmr = 0; end
      else if (m_act == 0) begin m_mode = IDLE; m_tmr = 0; end
      else if (m_tmr == 15) begin
        m_act -= 8; m_tmr = 0;
        if (m_act == 0) m_mode = IDLE;
      end else m_tmr++;
    end
    // Only checker 0 can be corrupted, so the lowest failing index is always 0.
    any = m_mm;
    if (sclr_err) begin
      m_sticky = any; m_cnt = any ? 1 : 0; m_idx = 0;
    end else if (any) begin
      if (!m_sticky) m_idx = 0;
      m_sticky = 1;
      if (m_cnt < 65535) m_cnt++;
    end
    m_mm   = sclr_err ? 1'b0 : (m_diff != 0);
    m_diff = sclr_err ? 32'h0 : (gstep(m_diff) ^ {31'b0, inject_err});
  endtask

  task automatic check_all();
    chk("dout", 32'(dout), 32'(m_dout));
    chk("active_chans", 32'(active_chans), 32'(m_act));
    chk("state", 32'(dbg_state), 32'(m_mode));
    chk("sticky_err", 32'(sticky_err), 32'(m_sticky));
    chk("err_count", 32'(err_count), 32'(m_cnt));
    chk("first_err_idx", 32'(first_err_idx), 32'(m_idx));
  endtask

  task automatic step_cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    int          cyc;
    logic        en;
    int          exp_act;
    ramp_state_e exp_st;
  } vec_t;

  vec_t tbl [22];

  initial begin
    bit [5:0] dref;
    tbl = '{
      '{16, 1'b1, 0, RAMP_UP},   '{1, 1'b1, 8, RAMP_UP},    '{16, 1'b1, 16, RAMP_UP},
      '{16, 1'b1, 24, RAMP_UP},  '{16, 1'b1, 32, RAMP_UP},  '{1, 1'b0, 32, RAMP_DOWN},
      '{15, 1'b0, 32, RAMP_DOWN},'{1, 1'b0, 24, RAMP_DOWN}, '{16, 1'b0, 16, RAMP_DOWN},
      '{1, 1'b1, 16, RAMP_UP},   '{15, 1'b1, 16, RAMP_UP},  '{1, 1'b1, 24, RAMP_UP},
      '{16, 1'b1, 32, RAMP_UP},  '{16, 1'b1, 40, RAMP_UP},  '{16, 1'b1, 48, RAMP_UP},
      '{16, 1'b1, 56, RAMP_UP},  '{16, 1'b1, 64, RUN},      '{20, 1'b1, 64, RUN},
      '{1, 1'b0, 64, RAMP_DOWN}, '{64, 1'b0, 32, RAMP_DOWN},'{64, 1'b0, 0, IDLE},
      '{5, 1'b0, 0, IDLE}
    };

    // Reset state, held asynchronously.
    m_reset();
    #12;
    chk("rst_active", 32'(active_chans), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_sticky", 32'(sticky_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    step_cyc();
    arst = 1'b0;

    // Ramp up, reversal and ramp down from the vector table.
    for (int r = 0; r < 22; r++) begin
      ena = tbl[r].en;
      repeat (tbl[r].cyc) step_cyc();
      chk($sformatf("tbl%0d_active", r), 32'(active_chans), 32'(tbl[r].exp_act));
      chk($sformatf("tbl%0d_state", r), 32'(dbg_state), 32'(tbl[r].exp_st));
    end

    // Single-cycle inject: sticky two edges later, then clear/priority.
    inject_err = 1'b1;
    step_cyc();
    inject_err = 1'b0;
    chk("inj_t0_sticky", 32'(sticky_err), 32'd0);
    step_cyc();
    chk("inj_t1_sticky", 32'(sticky_err), 32'd0);
    step_cyc();
    chk("inj_t2_sticky", 32'(sticky_err), 32'd1);
    chk("inj_t2_idx", 32'(first_err_idx), 32'd0);
    chk("inj_t2_count", 32'(err_count), 32'd1);
    repeat (3) step_cyc();
    chk("inj_t5_count", 32'(err_count), 32'd4);
    sclr_err = 1'b1;
    step_cyc();
    chk("sclr_prio_sticky", 32'(sticky_err), 32'd1);
    chk("sclr_prio_count", 32'(err_count), 32'd1);
    step_cyc();
    sclr_err = 1'b0;
    chk("sclr_alone_sticky", 32'(sticky_err), 32'd0);
    chk("sclr_alone_count", 32'(err_count), 32'd0);
    chk("sclr_alone_idx", 32'(first_err_idx), 32'd0);
    repeat (8) step_cyc();
    chk("sclr_quiet_sticky", 32'(sticky_err), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) ena = ~ena;
      if ($urandom_range(0, 31) == 0) duty = 4'($urandom_range(0, 15));
      inject_err = ($urandom_range(0, 149) == 0);
      sclr_err   = ($urandom_range(0, 99) == 0);
      step_cyc();
    end
    inject_err = 1'b0;
    sclr_err   = 1'b0;

    // Reach RUN, then duty=0 freezes every lane.
    ena  = 1'b1;
    duty = 4'd9;
    repeat (200) step_cyc();
    chk("run_reached", 32'(dbg_state), 32'(RUN));
    duty = 4'd0;
    repeat (3) step_cyc();
    dref = {5'b0, m_dout};
    for (int c = 0; c < 32; c++) begin
      step_cyc();
      chk("duty0_dout_const", 32'(dout), 32'(dref));
    end

    // Asynchronous reset in RUN takes effect before the next clock edge.
    duty = 4'd15;
    repeat (20) step_cyc();
    #2 arst = 1'b1;
    #1;
    chk("arst_active", 32'(active_chans), 32'd0);
    chk("arst_dout", 32'(dout), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(IDLE));
    m_reset();
    @(negedge clk);
    arst = 1'b0;
    ena  = 1'b0;
    repeat (4) step_cyc();
    chk("post_arst_active", 32'(active_chans), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/toggle_storm.md
TOGGLE_STORM -- requirements
Module: toggle_storm

Interface
REQ-001 SHALL have parameter NUM_CHAN, default 64, number of toggle lanes; multiple of 8, 8..1024.
REQ-002 SHALL have parameter ADD_BITS, default 6, lane accumulator width, 4..16.
REQ-003 SHALL have parameter DUTY_BITS, default 4, burst duty-control width.
REQ-004 SHALL have parameter RAMP_STEP, default 16, cycles per ramp step, >=1.
REQ-005 SHALL have parameter CHECKERS, default 16, number of integrity checkers, 1..64.
REQ-006 SHALL have port clk, input, 1, sole clock.
REQ-007 SHALL have port arst, input, 1, reset, asynchronous and active-high.
REQ-008 SHALL have port ena, input, 1, load requested.
REQ-009 SHALL have port duty, input, DUTY_BITS, burst on-cycles per 2^DUTY_BITS window.
REQ-010 SHALL have port sclr_err, input, 1, synchronous error-state clear.
REQ-011 SHALL have port inject_err, input, 1, test fault into checker 0.
REQ-012 SHALL have port dout, output, 1, registered XOR of all lane accumulators.
REQ-013 SHALL have port active_chans, output, clog2(NUM_CHAN)+1, lanes currently enabled.
REQ-014 SHALL have port sticky_err, output, 1, latched checker failure.
REQ-015 SHALL have port err_count, output, 16, saturating count of failing cycles.
REQ-016 SHALL have port first_err_idx, output, 6, index of first failing checker.

Function
REQ-017 Ramp FSM SHALL have states IDLE, RAMP_UP, RUN, RAMP_DOWN.
REQ-018 IDLE with ena=1 -> RAMP_UP; RAMP_UP adds 8 to active_chans every RAMP_STEP cycles; reaching NUM_CHAN -> RUN.
REQ-019 ena=0 in RAMP_UP or RUN -> RAMP_DOWN; subtract 8 every RAMP_STEP cycles; reaching 0 -> IDLE.
REQ-020 ena=1 in RAMP_DOWN -> RAMP_UP, continuing from the current active_chans; step timer restarts at 0 on every state change.
REQ-021 Duty counter SHALL free-run 0..2^DUTY_BITS-1 with wrap; burst_on = (counter < duty); duty=0 disables all lanes.
REQ-022 Lane i SHALL be enabled when i < active_chans and burst_on; enables SHALL be registered once before use.
REQ-023 An enabled lane SHALL update acc_i <= rotl1(acc_i) + ((i+1) mod 2^ADD_BITS); a disabled lane SHALL hold.
REQ-024 dout SHALL equal the XOR-reduce of all acc_i, registered, one cycle after the accumulator update.
REQ-025 Each checker SHALL run two 32-bit Galois LFSRs (primary, shadow), polynomial 0x80200003, seed 0x00000001 + checker index, stepping every cycle.
REQ-026 inject_err=1 SHALL invert bit 0 of checker 0's shadow LFSR next state for that cycle.
REQ-027 Per-checker mismatch SHALL be registered; the OR-reduce SHALL be registered again; sticky_err SHALL rise 2 cycles after the corrupted LFSR state appears.
REQ-028 err_count SHALL increment once per cycle in which the OR-reduced mismatch is 1, saturating at 0xFFFF.
REQ-029 first_err_idx SHALL capture the lowest-numbered failing checker on the cycle sticky_err goes 0->1, and hold thereafter.
REQ-030 sclr_err SHALL clear sticky_err, err_count and first_err_idx, and reseed both LFSRs of every checker.
REQ-031 sclr_err and a registered mismatch in the same cycle: error SHALL win (sticky_err=1, err_count=1, first_err_idx captured).
REQ-032 Checkers SHALL run independently of ena and the ramp state.

Reset
REQ-033 arst SHALL force: FSM=IDLE, active_chans=0, all acc_i=0, duty counter=0, dout=0, sticky_err=0, err_count=0, first_err_idx=0, LFSRs=seed.
REQ-034 arst asserted mid-ramp SHALL drop all lanes immediately, with no ramp-down.

Structure
REQ-035 Package toggle_storm_pkg SHALL hold the FSM state enum, LFSR polynomial, base seed and the ramp increment (8).
REQ-036 Checker SHALL be sub-module lfsr_pair_check (ports clk, arst, sclr, inject, mismatch).

Verification
REQ-037 Ramp: NUM_CHAN=64, RAMP_STEP=16, ena 0->1 -> active_chans steps 8,16,...,64 every 16 cycles; RUN entered after 128 cycles.
REQ-038 Reversal: ena drops at active_chans=32 -> 24,16; ena rises at 16 -> 24 after 16 cycles, then RAMP_UP.
REQ-039 Duty: duty=4, DUTY_BITS=4 -> lanes update exactly 4 of every 16 cycles; duty=0 -> dout constant.
REQ-040 Inject: one-cycle inject_err at cycle T -> sticky_err=1 at T+2 (or later per REQ-027), first_err_idx=0, err_count stops at the number of mismatch cycles.
REQ-041 Clear/priority: sclr_err coincident with a mismatch -> sticky_err stays 1, err_count=1; sclr_err alone -> all error outputs 0.
REQ-042 Reset: arst in RUN -> active_chans=0, dout=0, FSM IDLE within the same cycle, asynchronously.
